mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM; drives the ALU's ALUOp interface and consumes its Zero flag.

---
 rtl/mc_ctrl_pkg.sv | 83 ++++++++
 rtl/mc_ctrl_if.sv | 30 +++
 rtl/mc_ctrl_alu_dec.sv | 83 ++++++++
 rtl/mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU codes, datapath selects, opcodes.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_JMP    = 3'd6
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP = 3'd7
`endif
  } state_t;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  localparam logic [1:0] NPC_ALU    = 2'b00;
  localparam logic [1:0] NPC_ALUOUT = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_31 = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  function automatic logic isMemOp(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the shared datapath (slave).
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic [1:0] NPCOp;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ALUSwap;
  logic       EXTOp;
  logic [3:0] ALUOp;

  modport master (
    input  Op, Funct, Zero,
    output PCWrite, NPCOp, IRWrite, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUSwap, EXTOp, ALUOp
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWrite, NPCOp, IRWrite, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, ALUSwap, EXTOp, ALUOp
  );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// Combinational ALU decode: (Op, Funct, state) -> ALUOp, operand swap, extension mode, legality.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  state_t     i_state,
  output logic [3:0] o_aluOp,
  output logic       o_aluSwap,
  output logic       o_extOp,
  output logic       o_legal
);

  logic [3:0] w_rAluOp;
  logic       w_rAluOk;
  logic       w_isR;

  assign w_isR = (i_op == OP_RTYPE);

  always_comb begin
    w_rAluOp = ALU_NOP;
    w_rAluOk = 1'b1;
    case (i_funct)
      FN_ADD:  w_rAluOp = ALU_ADD;
      FN_SUB:  w_rAluOp = ALU_SUB;
      FN_AND:  w_rAluOp = ALU_AND;
      FN_OR:   w_rAluOp = ALU_OR;
      FN_NOR:  w_rAluOp = ALU_NOR;
      FN_SLT:  w_rAluOp = ALU_SLT;
      FN_SLTU: w_rAluOp = ALU_SLTU;
      FN_SLL, FN_SLLV: w_rAluOp = ALU_SLL;
      FN_SRL, FN_SRLV: w_rAluOp = ALU_SRL;
      default: w_rAluOk = 1'b0;
    endcase
  end

  always_comb begin
    o_legal = 1'b0;
    case (i_op)
      OP_RTYPE: o_legal = w_rAluOk || (i_funct == FN_JR) || (i_funct == FN_JALR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: o_legal = 1'b1;
      default: o_legal = 1'b0;
    endcase
  end

  // The ALU shifts right as A>>B but left as B<<A, so srl/srlv swap operands
  always_comb begin
    o_aluOp   = ALU_NOP;
    o_aluSwap = 1'b0;
    o_extOp   = 1'b0;
    case (i_state)
      S_FETCH: o_aluOp = ALU_ADD;
      S_DECODE: begin
        o_aluOp = ALU_ADD;
        o_extOp = 1'b1;
      end
      S_EXEC: begin
        if (w_isR) begin
          o_aluOp   = w_rAluOp;
          o_aluSwap = (i_funct == FN_SRL) || (i_funct == FN_SRLV);
        end else begin
          case (i_op)
            OP_ADDI: begin o_aluOp = ALU_ADD; o_extOp = 1'b1; end
            OP_SLTI: begin o_aluOp = ALU_SLT; o_extOp = 1'b1; end
            OP_ANDI: o_aluOp = ALU_AND;
            OP_ORI:  o_aluOp = ALU_OR;
            OP_LUI:  o_aluOp = ALU_LUI;
            default: begin
              if (isMemOp(i_op)) begin
                o_aluOp = ALU_ADD;
                o_extOp = 1'b1;
              end
            end
          endcase
        end
      end
      S_BR: o_aluOp = ALU_SUB;
      default: o_aluOp = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB/BR/JMP and counts retirements.
// Define CTRL_ILLEGAL_TRAP_EN to park illegal instructions in a TRAP state instead of skipping them.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rstn,
  mc_ctrl_if.master        ctrlBus,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_instrCnt;

  logic       w_legal;
  logic       w_retire;
  logic       w_pcWrite;
  logic       w_irWrite;
  logic       w_memWrite;
  logic       w_regWrite;
  logic       w_isR;
  logic       w_isJr;
  logic       w_isJalr;
  logic       w_isShiftImm;

  assign w_isR        = (ctrlBus.Op == OP_RTYPE);
  assign w_isJr       = w_isR && (ctrlBus.Funct == FN_JR);
  assign w_isJalr     = w_isR && (ctrlBus.Funct == FN_JALR);
  assign w_isShiftImm = w_isR && ((ctrlBus.Funct == FN_SLL) || (ctrlBus.Funct == FN_SRL));

  mc_alu_dec u_aluDec (
    .i_op      (ctrlBus.Op),
    .i_funct   (ctrlBus.Funct),
    .i_state   (r_state),
    .o_aluOp   (ctrlBus.ALUOp),
    .o_aluSwap (ctrlBus.ALUSwap),
    .o_extOp   (ctrlBus.EXTOp),
    .o_legal   (w_legal)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_FETCH;
      r_instrCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_retire) r_instrCnt <= r_instrCnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_retire        = 1'b0;
    w_pcWrite       = 1'b0;
    w_irWrite       = 1'b0;
    w_memWrite      = 1'b0;
    w_regWrite      = 1'b0;
    ctrlBus.NPCOp   = NPC_ALU;
    ctrlBus.RegDst  = RD_RT;
    ctrlBus.WDSel   = WD_ALUOUT;
    ctrlBus.ALUSrcA = SRCA_PC;
    ctrlBus.ALUSrcB = SRCB_B;
    case (r_state)
      S_FETCH: begin
        ctrlBus.ALUSrcB = SRCB_4;
        w_pcWrite       = 1'b1;
        w_irWrite       = 1'b1;
        w_nextState     = S_DECODE;
      end
      S_DECODE: begin
        ctrlBus.ALUSrcB = SRCB_IMM4;
        if (!w_legal)
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_nextState = S_TRAP;
`else
          w_nextState = S_FETCH;
`endif
        else if ((ctrlBus.Op == OP_BEQ) || (ctrlBus.Op == OP_BNE))
          w_nextState = S_BR;
        else if ((ctrlBus.Op == OP_J) || (ctrlBus.Op == OP_JAL) || w_isJr || w_isJalr)
          w_nextState = S_JMP;
        else
          w_nextState = S_EXEC;
      end
      S_EXEC: begin
        ctrlBus.ALUSrcA = w_isShiftImm ? SRCA_SHAMT : SRCA_A;
        ctrlBus.ALUSrcB = w_isR ? SRCB_B : SRCB_IMM;
        w_nextState     = isMemOp(ctrlBus.Op) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (ctrlBus.Op == OP_SW) begin
          w_memWrite  = 1'b1;
          w_retire    = 1'b1;
          w_nextState = S_FETCH;
        end else begin
          w_nextState = S_WB;
        end
      end
      S_WB: begin
        w_regWrite     = 1'b1;
        ctrlBus.RegDst = w_isR ? RD_RD : RD_RT;
        ctrlBus.WDSel  = (ctrlBus.Op == OP_LW) ? WD_MDR : WD_ALUOUT;
        w_retire       = 1'b1;
        w_nextState    = S_FETCH;
      end
      S_BR: begin
        ctrlBus.ALUSrcA = SRCA_A;
        ctrlBus.NPCOp   = NPC_ALUOUT;
        w_pcWrite       = (ctrlBus.Op == OP_BEQ) ? ctrlBus.Zero : ~ctrlBus.Zero;
        w_retire        = 1'b1;
        w_nextState     = S_FETCH;
      end
      // PC already holds PC+4 here, so the link value is taken straight from PC
      S_JMP: begin
        w_pcWrite     = 1'b1;
        ctrlBus.NPCOp = w_isR ? NPC_RS : NPC_JUMP;
        if (ctrlBus.Op == OP_JAL) begin
          w_regWrite     = 1'b1;
          ctrlBus.RegDst = RD_31;
          ctrlBus.WDSel  = WD_PC;
        end else if (w_isJalr) begin
          w_regWrite     = 1'b1;
          ctrlBus.RegDst = RD_RD;
          ctrlBus.WDSel  = WD_PC;
        end
        w_retire    = 1'b1;
        w_nextState = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: w_nextState = S_TRAP;
`endif
      default: w_nextState = S_FETCH;
    endcase
  end

  assign ctrlBus.PCWrite  = w_pcWrite  & rstn;
  assign ctrlBus.IRWrite  = w_irWrite  & rstn;
  assign ctrlBus.MemWrite = w_memWrite & rstn;
  assign ctrlBus.RegWrite = w_regWrite & rstn;
  assign instr_cnt        = r_instrCnt;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control words come from an instruction-level model.
// Honors CTRL_ILLEGAL_TRAP_EN the same way as the design build.
module tb_mc_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CW-1:0] instr_cnt;
  logic          illegal;

  mc_ctrl_if busIf();

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ctrlBus   (busIf),
    .instr_cnt (instr_cnt),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          PCWrite;
    logic [1:0]    NPCOp;
    logic          IRWrite;
    logic          MemWrite;
    logic          RegWrite;
    logic [1:0]    RegDst;
    logic [1:0]    WDSel;
    logic [1:0]    ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic          ALUSwap;
    logic          EXTOp;
    logic [3:0]    ALUOp;
    logic          illegal;
    logic [CW-1:0] cnt;
  } ctl_t;

  ctl_t        expQ[$];
  string       tagQ[$];
  int          checkCount = 0;
  int          passCount = 0;
  int unsigned modelCnt = 0;
  logic [3:0]  aluOf[string];
  bit          rAlu[string];
  logic [11:0] tbl[$];
  ctl_t        monAct;
  ctl_t        monExp;
  string       monTag;

  function automatic string mnem(input logic [5:0] op, input logic [5:0] fn);
    string m;
    m = "ill";
    case (op)
      6'h00: case (fn)
        6'h20: m = "add";  6'h22: m = "sub";  6'h24: m = "and";  6'h25: m = "or";
        6'h27: m = "nor";  6'h2a: m = "slt";  6'h2b: m = "sltu"; 6'h00: m = "sll";
        6'h02: m = "srl";  6'h04: m = "sllv"; 6'h06: m = "srlv"; 6'h08: m = "jr";
        6'h09: m = "jalr";
        default: m = "ill";
      endcase
      6'h02: m = "j";    6'h03: m = "jal";  6'h04: m = "beq";  6'h05: m = "bne";
      6'h08: m = "addi"; 6'h0a: m = "slti"; 6'h0c: m = "andi"; 6'h0d: m = "ori";
      6'h0f: m = "lui";  6'h23: m = "lw";   6'h2b: m = "sw";
      default: m = "ill";
    endcase
    return m;
  endfunction

  function automatic ctl_t word(input string ph, input string m, input logic z, input int unsigned cnt);
    ctl_t w;
    w = '0;
    w.cnt = cnt[CW-1:0];
    if (ph == "fetch") begin
      w.PCWrite = 1'b1; w.IRWrite = 1'b1; w.ALUSrcB = 2'd1; w.ALUOp = 4'd1;
    end else if (ph == "decode") begin
      w.ALUSrcB = 2'd3; w.EXTOp = 1'b1; w.ALUOp = 4'd1;
    end else if (ph == "exec") begin
      w.ALUOp = aluOf[m];
      if (rAlu.exists(m)) begin
        w.ALUSrcA = (m == "sll" || m == "srl") ? 2'd2 : 2'd1;
        w.ALUSwap = (m == "srl" || m == "srlv");
      end else begin
        w.ALUSrcA = 2'd1;
        w.ALUSrcB = 2'd2;
        w.EXTOp   = (m == "addi" || m == "slti" || m == "lw" || m == "sw");
      end
    end else if (ph == "mem") begin
      w.MemWrite = (m == "sw");
    end else if (ph == "wb") begin
      w.RegWrite = 1'b1;
      w.RegDst   = rAlu.exists(m) ? 2'd1 : 2'd0;
      w.WDSel    = (m == "lw") ? 2'd1 : 2'd0;
    end else if (ph == "br") begin
      w.ALUSrcA = 2'd1; w.ALUOp = 4'd2; w.NPCOp = 2'd1;
      w.PCWrite = (m == "beq") ? z : ~z;
    end else if (ph == "jmp") begin
      w.PCWrite = 1'b1;
      w.NPCOp   = (m == "j" || m == "jal") ? 2'd2 : 2'd3;
      if (m == "jal")  begin w.RegWrite = 1'b1; w.RegDst = 2'd2; w.WDSel = 2'd2; end
      if (m == "jalr") begin w.RegWrite = 1'b1; w.RegDst = 2'd1; w.WDSel = 2'd2; end
    end else if (ph == "trap") begin
      w.illegal = 1'b1;
    end
    return w;
  endfunction

  function automatic ctl_t maskEnables(input ctl_t w);
    ctl_t r;
    r = w;
    r.PCWrite = 1'b0; r.IRWrite = 1'b0; r.MemWrite = 1'b0; r.RegWrite = 1'b0;
    return r;
  endfunction

  // One instruction, one expected word per cycle; abortAt pulls rstn low in that cycle
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int abortAt, input int zMode);
    string m;
    string ph[$];
    logic  z;
    ctl_t  w;
    m  = mnem(op, fn);
    ph = {"fetch", "decode"};
    if (rAlu.exists(m) || m == "addi" || m == "slti" || m == "andi" || m == "ori" || m == "lui")
      ph = {ph, "exec", "wb"};
    else if (m == "lw")  ph = {ph, "exec", "mem", "wb"};
    else if (m == "sw")  ph = {ph, "exec", "mem"};
    else if (m == "beq" || m == "bne") ph.push_back("br");
    else if (m == "ill") begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      ph = {ph, "trap", "trap", "trap"};
`endif
    end else ph.push_back("jmp");
    for (int k = 0; k < ph.size(); k++) begin
      @(posedge clk); #1;
      busIf.Op    = op;
      busIf.Funct = fn;
      z = (ph[k] == "br" && zMode >= 0) ? zMode[0] : 1'($urandom_range(0, 1));
      busIf.Zero  = z;
      rstn = (k == abortAt) ? 1'b0 : 1'b1;
      w = word(ph[k], m, z, modelCnt);
      if (!rstn) w = maskEnables(w);
      expQ.push_back(w);
      tagQ.push_back({m, "/", ph[k]});
      if (k == abortAt) begin
        modelCnt = 0;
        return;
      end
    end
    if (m != "ill") modelCnt = (modelCnt + 1) % (1 << CW);
`ifdef CTRL_ILLEGAL_TRAP_EN
    else begin
      @(posedge clk); #1;
      rstn = 1'b0;
      expQ.push_back(word("trap", m, 1'b0, modelCnt));
      tagQ.push_back("trapReset1");
      @(posedge clk); #1;
      modelCnt = 0;
      expQ.push_back(maskEnables(word("fetch", m, 1'b0, 0)));
      tagQ.push_back("trapReset2");
    end
`endif
  endtask

  task automatic checkOutput(input string name, input ctl_t act, input ctl_t exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: one control word per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      monTag = tagQ.pop_front();
      monAct.PCWrite  = busIf.PCWrite;
      monAct.NPCOp    = busIf.NPCOp;
      monAct.IRWrite  = busIf.IRWrite;
      monAct.MemWrite = busIf.MemWrite;
      monAct.RegWrite = busIf.RegWrite;
      monAct.RegDst   = busIf.RegDst;
      monAct.WDSel    = busIf.WDSel;
      monAct.ALUSrcA  = busIf.ALUSrcA;
      monAct.ALUSrcB  = busIf.ALUSrcB;
      monAct.ALUSwap  = busIf.ALUSwap;
      monAct.EXTOp    = busIf.EXTOp;
      monAct.ALUOp    = busIf.ALUOp;
      monAct.illegal  = illegal;
      monAct.cnt      = instr_cnt;
      checkOutput(monTag, monAct, monExp);
    end
  end

  initial begin
    aluOf["add"] = 4'd1;  aluOf["sub"] = 4'd2;  aluOf["and"] = 4'd3;  aluOf["or"] = 4'd4;
    aluOf["slt"] = 4'd5;  aluOf["sltu"] = 4'd6; aluOf["sll"] = 4'd7;  aluOf["sllv"] = 4'd7;
    aluOf["nor"] = 4'd8;  aluOf["srl"] = 4'd9;  aluOf["srlv"] = 4'd9; aluOf["lui"] = 4'd10;
    aluOf["addi"] = 4'd1; aluOf["andi"] = 4'd3; aluOf["ori"] = 4'd4;  aluOf["slti"] = 4'd5;
    aluOf["lw"] = 4'd1;   aluOf["sw"] = 4'd1;
    foreach (aluOf[k]) if (k == "add" || k == "sub" || k == "and" || k == "or" || k == "nor" ||
                           k == "slt" || k == "sltu" || k == "sll" || k == "srl" ||
                           k == "sllv" || k == "srlv") rAlu[k] = 1'b1;
    tbl = {{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h27},
           {6'h00, 6'h2a}, {6'h00, 6'h2b}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h04},
           {6'h00, 6'h06}, {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h02, 6'h11}, {6'h03, 6'h05},
           {6'h04, 6'h13}, {6'h05, 6'h2c}, {6'h08, 6'h01}, {6'h0a, 6'h3e}, {6'h0c, 6'h07},
           {6'h0d, 6'h10}, {6'h0f, 6'h00}, {6'h23, 6'h04}, {6'h2b, 6'h08}, {6'h3f, 6'h00},
           {6'h00, 6'h21}};

    busIf.Op = 6'h00; busIf.Funct = 6'h00; busIf.Zero = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    expQ.push_back(maskEnables(word("fetch", "add", 1'b0, 0)));
    tagQ.push_back("reset");

    applyStimulus(6'h00, 6'h20, -1, -1);
    applyStimulus(6'h00, 6'h02, -1, -1);
    applyStimulus(6'h0f, 6'h00, -1, -1);
    applyStimulus(6'h23, 6'h00, -1, -1);
    applyStimulus(6'h2b, 6'h00, -1, -1);
    applyStimulus(6'h04, 6'h00, -1, 1);
    applyStimulus(6'h04, 6'h00, -1, 0);
    applyStimulus(6'h05, 6'h00, -1, 1);
    applyStimulus(6'h05, 6'h00, -1, 0);
    applyStimulus(6'h03, 6'h00, -1, -1);
    applyStimulus(6'h00, 6'h09, -1, -1);
    applyStimulus(6'h3f, 6'h00, -1, -1);
    applyStimulus(6'h00, 6'h21, -1, -1);
    applyStimulus(6'h23, 6'h00, 2, -1);
    applyStimulus(6'h00, 6'h20, 3, -1);

    for (int n = 0; n < 340; n++) begin
      int idx;
      idx = $urandom_range(0, tbl.size() - 1);
      applyStimulus(tbl[idx][11:6], tbl[idx][5:0], -1, -1);
    end

    repeat (3) @(negedge clk);
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL drain: got %0d pending required 0", expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
